axi_slave_mem: RTL and testbench

//   AXI4-full slave responder backed by an internal word-addressed memory. It is the far end of burst_axi's M_AXI write and read channels.
//   It replaces the ad-hoc ready/valid stubs in the DMA benches and is also usable as an on-chip scratch RAM. Write and read channels are independent, with one outstanding transaction per direction.

---
 rtl/axi_slave_mem.sv | 205 ++++++++++++++++++++
 tb/tb_axi_slave_mem.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_slave_mem.sv
// AXI4 INCR-only slave backed by a word-addressed RAM. It has independent write and read
// channels, with one outstanding burst per direction.
module axi_slave_mem #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int MEM_DEPTH_LOG2     = 10
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [7:0]                        S_AXI_AWLEN,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WLAST,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [7:0]                        S_AXI_ARLEN,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RLAST,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY
);
    localparam int STRB_W   = C_S_AXI_DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam int DEPTH    = 1 << MEM_DEPTH_LOG2;

    typedef logic [MEM_DEPTH_LOG2-1:0] idx_t;
    localparam idx_t IDX_ONE = idx_t'(1);

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
    typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

    logic [C_S_AXI_DATA_WIDTH-1:0] mem_r [DEPTH];

    w_state_t                      w_state_r;
    idx_t                          w_idx_r;
    logic [7:0]                    w_len_r;
    logic [7:0]                    w_cnt_r;
    logic                          w_err_r;
    logic                          awready_r;
    logic                          wready_r;
    logic                          bvalid_r;
    logic [1:0]                    bresp_r;

    r_state_t                      r_state_r;
    idx_t                          r_idx_r;
    logic [7:0]                    r_len_r;
    logic [7:0]                    r_cnt_r;
    logic                          arready_r;
    logic                          rvalid_r;
    logic                          rlast_r;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_r;

    idx_t aw_idx_s;
    idx_t ar_idx_s;
    logic w_beat_s;
    logic unused_addr_bits_s;

    // Byte offset and bits above the memory depth are dropped, so indices wrap modulo depth.
    assign aw_idx_s           = S_AXI_AWADDR[ADDR_LSB +: MEM_DEPTH_LOG2];
    assign ar_idx_s           = S_AXI_ARADDR[ADDR_LSB +: MEM_DEPTH_LOG2];
    assign unused_addr_bits_s = ^{S_AXI_AWADDR, S_AXI_ARADDR};
    assign w_beat_s           = (w_state_r == W_DATA) && wready_r && S_AXI_WVALID;

    // Byte-masked RAM write; contents deliberately survive reset.
    always_ff @(posedge S_AXI_ACLK) begin
        if (w_beat_s) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (S_AXI_WSTRB[b]) begin
                    mem_r[w_idx_r][b*8 +: 8] <= S_AXI_WDATA[b*8 +: 8];
                end
            end
        end
    end

    // Write channel FSM: address accept, data beats, response.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            w_state_r <= W_IDLE;
            w_idx_r   <= '0;
            w_len_r   <= 8'd0;
            w_cnt_r   <= 8'd0;
            w_err_r   <= 1'b0;
            awready_r <= 1'b0;
            wready_r  <= 1'b0;
            bvalid_r  <= 1'b0;
            bresp_r   <= 2'b00;
        end else begin
            case (w_state_r)
                W_IDLE: begin
                    awready_r <= 1'b1;
                    if (awready_r && S_AXI_AWVALID) begin
                        w_idx_r   <= aw_idx_s;
                        w_len_r   <= S_AXI_AWLEN;
                        w_cnt_r   <= 8'd0;
                        w_err_r   <= 1'b0;
                        awready_r <= 1'b0;
                        wready_r  <= 1'b1;
                        w_state_r <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_beat_s) begin
                        w_idx_r <= w_idx_r + IDX_ONE;
                        w_cnt_r <= w_cnt_r + 8'd1;
                        // AWLEN alone ends the burst; a WLAST mismatch only taints BRESP.
                        if (w_cnt_r == w_len_r) begin
                            wready_r  <= 1'b0;
                            bvalid_r  <= 1'b1;
                            bresp_r   <= (w_err_r || !S_AXI_WLAST) ? 2'b10 : 2'b00;
                            w_state_r <= W_RESP;
                        end else begin
                            w_err_r <= w_err_r | S_AXI_WLAST;
                        end
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        bvalid_r  <= 1'b0;
                        bresp_r   <= 2'b00;
                        awready_r <= 1'b1;
                        w_state_r <= W_IDLE;
                    end
                end
                default: begin
                    awready_r <= 1'b0;
                    wready_r  <= 1'b0;
                    bvalid_r  <= 1'b0;
                    bresp_r   <= 2'b00;
                    w_state_r <= W_IDLE;
                end
            endcase
        end
    end

    // Read channel FSM: RDATA is registered from the RAM, so a same-cycle write returns old data.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_state_r <= R_IDLE;
            r_idx_r   <= '0;
            r_len_r   <= 8'd0;
            r_cnt_r   <= 8'd0;
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rlast_r   <= 1'b0;
            rdata_r   <= '0;
        end else begin
            case (r_state_r)
                R_IDLE: begin
                    arready_r <= 1'b1;
                    if (arready_r && S_AXI_ARVALID) begin
                        rdata_r   <= mem_r[ar_idx_s];
                        rlast_r   <= (S_AXI_ARLEN == 8'd0);
                        rvalid_r  <= 1'b1;
                        arready_r <= 1'b0;
                        r_idx_r   <= ar_idx_s + IDX_ONE;
                        r_len_r   <= S_AXI_ARLEN;
                        r_cnt_r   <= 8'd0;
                        r_state_r <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        if (rlast_r) begin
                            rvalid_r  <= 1'b0;
                            rlast_r   <= 1'b0;
                            arready_r <= 1'b1;
                            r_state_r <= R_IDLE;
                        end else begin
                            rdata_r <= mem_r[r_idx_r];
                            r_idx_r <= r_idx_r + IDX_ONE;
                            r_cnt_r <= r_cnt_r + 8'd1;
                            rlast_r <= ((r_cnt_r + 8'd1) == r_len_r);
                        end
                    end
                end
                default: begin
                    arready_r <= 1'b0;
                    rvalid_r  <= 1'b0;
                    rlast_r   <= 1'b0;
                    r_state_r <= R_IDLE;
                end
            endcase
        end
    end

    assign S_AXI_AWREADY = awready_r;
    assign S_AXI_WREADY  = wready_r;
    assign S_AXI_BVALID  = bvalid_r;
    assign S_AXI_BRESP   = bresp_r;
    assign S_AXI_ARREADY = arready_r;
    assign S_AXI_RVALID  = rvalid_r;
    assign S_AXI_RLAST   = rlast_r;
    assign S_AXI_RDATA   = rdata_r;
    assign S_AXI_RRESP   = 2'b00;
endmodule

// File: tb/tb_axi_slave_mem.sv
// Randomised bench for axi_slave_mem. A word-array memory model predicts every
// read beat and write response, and a negedge monitor compares them against the DUT.
module tb_axi_slave_mem;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] awaddr = 32'd0, araddr = 32'd0, wdata = 32'd0;
    logic [7:0]  awlen = 8'd0, arlen = 8'd0;
    logic [3:0]  wstrb = 4'd0;
    logic        awvalid = 1'b0, wlast = 1'b0, wvalid = 1'b0, bready = 1'b0;
    logic        arvalid = 1'b0, rready = 1'b0;
    logic        awready, wready, bvalid, arready, rlast, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;

    always #5 clk = ~clk;

    axi_slave_mem dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast), .S_AXI_WVALID(wvalid),
        .S_AXI_WREADY(wready), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast), .S_AXI_RVALID(rvalid),
        .S_AXI_RREADY(rready)
    );

    logic [31:0] model_mem [DEPTH];
    logic [31:0] wd [256];
    logic [3:0]  ws [256];
    logic [31:0] exp_rd_q [$];
    logic        exp_rl_q [$];
    logic [1:0]  exp_b_q [$];
    int n_cmp = 0, n_err = 0, cyc = 0, aw_cyc = 0, ar_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: expected event did not occur (t=%0t)", name, $time);
    endtask

    function automatic logic sig(input int id);
        case (id)
            0:       return awready;
            1:       return wready;
            2:       return arready;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int id, input string name);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!sig(id) && k < 200);
        if (!sig(id)) fail(name);
    endtask

    // Monitor: each new R/B beat pops a model expectation; stalled beats must keep matching it.
    initial begin : monitor
        logic [31:0] cur_d;
        logic        cur_l, cur_v, cur_bv;
        logic [1:0]  cur_b;
        cur_v = 1'b0;
        cur_bv = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cur_v = 1'b0;
                cur_bv = 1'b0;
            end else begin
                if (rvalid) begin
                    if (!cur_v) begin
                        if (exp_rd_q.size() == 0) fail("rvalid_unexpected");
                        else begin
                            cur_d = exp_rd_q.pop_front();
                            cur_l = exp_rl_q.pop_front();
                            cur_v = 1'b1;
                        end
                    end
                    if (cur_v) begin
                        check("rdata", rdata, cur_d);
                        check("rlast", {31'd0, rlast}, {31'd0, cur_l});
                        check("rresp", {30'd0, rresp}, 32'd0);
                    end
                    if (rready) cur_v = 1'b0;
                end else cur_v = 1'b0;
                if (bvalid) begin
                    if (!cur_bv) begin
                        if (exp_b_q.size() == 0) fail("bvalid_unexpected");
                        else begin
                            cur_b = exp_b_q.pop_front();
                            cur_bv = 1'b1;
                        end
                    end
                    if (cur_bv) check("bresp", {30'd0, bresp}, {30'd0, cur_b});
                    if (bready) cur_bv = 1'b0;
                end else cur_bv = 1'b0;
            end
        end
    end

    task automatic model_write(input logic [9:0] ix, input logic [31:0] d, input logic [3:0] s);
        for (int b = 0; b < 4; b++) begin
            if (s[b]) model_mem[ix][8*b +: 8] = d[8*b +: 8];
        end
    endtask

    // early < 0 means WLAST on the true last beat; otherwise WLAST only on beat 'early'.
    task automatic do_write(input logic [31:0] addr, input int len, input int early, input int bdelay);
        logic       err;
        logic       wl;
        logic [9:0] ix;
        err = 1'b0;
        ix = addr[11:2];
        for (int i = 0; i <= len; i++) begin
            wl = (early >= 0) ? (i == early) : (i == len);
            if (wl != (i == len)) err = 1'b1;
        end
        exp_b_q.push_back(err ? 2'b10 : 2'b00);
        @(posedge clk); #1;
        awaddr = addr; awlen = len[7:0]; awvalid = 1'b1;
        wait_for(0, "aw_handshake");
        @(posedge clk);
        aw_cyc = cyc;
        #1 awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            wdata = wd[i]; wstrb = ws[i];
            wlast = (early >= 0) ? (i == early) : (i == len);
            wvalid = 1'b1;
            wait_for(1, "w_beat");
            @(posedge clk);
            model_write(ix, wd[i], ws[i]);
            ix = ix + 10'd1;
            #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        @(negedge clk);
        check("bvalid_after_last", {31'd0, bvalid}, 32'd1);
        check("wready_after_last", {31'd0, wready}, 32'd0);
        for (int k = 0; k < bdelay; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("bvalid_held", {31'd0, bvalid}, 32'd1);
            check("awready_low_in_resp", {31'd0, awready}, 32'd0);
        end
        @(posedge clk); #1 bready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1 bready = 1'b0;
        @(negedge clk);
        check("awready_after_b", {31'd0, awready}, 32'd1);
        check("bvalid_after_b", {31'd0, bvalid}, 32'd0);
    endtask

    // mode 0: RREADY always high, 1: alternating 1,0,..., 2: random.
    task automatic do_read(input logic [31:0] addr, input int len, input int mode);
        int cnt = 0, it = 0;
        logic [9:0] ix;
        ix = addr[11:2];
        for (int i = 0; i <= len; i++) begin
            exp_rd_q.push_back(model_mem[ix + 10'(i)]);
            exp_rl_q.push_back(i == len);
        end
        @(posedge clk); #1;
        araddr = addr; arlen = len[7:0]; arvalid = 1'b1;
        wait_for(2, "ar_handshake");
        @(posedge clk);
        ar_cyc = cyc;
        #1 arvalid = 1'b0;
        while (cnt <= len && it < 600) begin
            case (mode)
                0:       rready = 1'b1;
                1:       rready = (it % 2 == 0);
                default: rready = 1'($urandom_range(1));
            endcase
            @(negedge clk);
            if (rvalid && rready) cnt++;
            @(posedge clk); #1;
            it++;
        end
        rready = 1'b0;
        if (cnt <= len) fail("r_beats");
        @(negedge clk);
        check("arready_after_r", {31'd0, arready}, 32'd1);
        check("rvalid_after_r", {31'd0, rvalid}, 32'd0);
        check("r_queue_drained", exp_rd_q.size(), 32'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1);
    end

    initial begin : stimulus
        #3;
        check("rst_awready", {31'd0, awready}, 32'd0);
        check("rst_wready",  {31'd0, wready},  32'd0);
        check("rst_bvalid",  {31'd0, bvalid},  32'd0);
        check("rst_arready", {31'd0, arready}, 32'd0);
        check("rst_rvalid",  {31'd0, rvalid},  32'd0);
        check("rst_rlast",   {31'd0, rlast},   32'd0);
        check("rst_bresp",   {30'd0, bresp},   32'd0);
        check("rst_rdata",   rdata,            32'd0);
        #20 rst_n = 1'b1;

        // Basic 4-beat burst and read-back.
        wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;
        for (int i = 0; i < 4; i++) ws[i] = 4'hF;
        do_write(32'h10, 3, -1, 0);
        check("model_w4", model_mem[10'd4], 32'h11);
        check("model_w7", model_mem[10'd7], 32'h44);
        do_read(32'h10, 3, 0);

        // Byte strobes.
        wd[0] = 32'hAABBCCDD; ws[0] = 4'hF;
        do_write(32'h0, 0, -1, 0);
        wd[0] = 32'h11223344; ws[0] = 4'b0101;
        do_write(32'h0, 0, -1, 0);
        check("model_strb", model_mem[10'd0], 32'hAA22CC44);
        do_read(32'h0, 0, 0);

        // Backpressure on both channels.
        for (int i = 0; i < 4; i++) begin wd[i] = 32'hB0B0_0000 + 32'(i); ws[i] = 4'hF; end
        do_write(32'h80, 3, -1, 5);
        do_read(32'h80, 3, 1);

        // Early WLAST flags SLVERR but the burst still runs all four beats.
        for (int i = 0; i < 4; i++) begin wd[i] = 32'hE0E0_0000 + 32'(i); ws[i] = 4'hF; end
        do_write(32'hC0, 3, 1, 0);
        do_write(32'hC0, 3, -1, 0);
        do_read(32'hC0, 3, 2);

        // Concurrent AW/AR, then wrap at the top of memory.
        wd[0] = 32'h2000_0001; wd[1] = 32'h2000_0002; ws[0] = 4'hF; ws[1] = 4'hF;
        do_write(32'h200, 1, -1, 0);
        wd[0] = 32'h1000_0001; wd[1] = 32'h1000_0002;
        fork
            do_write(32'h100, 1, -1, 0);
            do_read(32'h200, 1, 0);
        join
        check("aw_ar_same_cycle", aw_cyc, ar_cyc);
        do_read(32'h100, 1, 0);
        wd[0] = 32'hCAFE0001; wd[1] = 32'hCAFE0002;
        do_write(32'h0000_0FFC, 1, -1, 0);
        check("model_wrap", model_mem[10'd0], 32'hCAFE0002);
        do_read(32'h0, 0, 0);
        do_read(32'h0000_0FFC, 1, 0);

        // Reset in the middle of a write burst.
        for (int i = 0; i < 4; i++) begin wd[i] = 32'h5E5E_0000 + 32'(i); ws[i] = 4'hF; end
        @(posedge clk); #1;
        awaddr = 32'h40; awlen = 8'd3; awvalid = 1'b1;
        wait_for(0, "aw_handshake_rst");
        @(posedge clk); #1 awvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wdata = wd[i]; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
            wait_for(1, "w_beat_rst");
            @(posedge clk);
            model_write(10'd16 + 10'(i), wd[i], 4'hF);
            #1;
        end
        wvalid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_awready", {31'd0, awready}, 32'd0);
        check("mid_rst_wready",  {31'd0, wready},  32'd0);
        check("mid_rst_bvalid",  {31'd0, bvalid},  32'd0);
        check("mid_rst_arready", {31'd0, arready}, 32'd0);
        check("mid_rst_rvalid",  {31'd0, rvalid},  32'd0);
        @(posedge clk); @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("awready_after_rst", {31'd0, awready}, 32'd1);
        do_read(32'h40, 1, 0);

        // Randomised bursts: full-strobe fill, random-strobe overwrite, random-backpressure read.
        for (int t = 0; t < 20; t++) begin
            logic [31:0] a;
            int len, early;
            a = $urandom;
            len = $urandom_range(15);
            for (int i = 0; i <= len; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
            do_write(a, len, -1, $urandom_range(3));
            for (int i = 0; i <= len; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom_range(15)); end
            early = ($urandom_range(3) == 0) ? $urandom_range(len) : -1;
            do_write(a, len, early, $urandom_range(3));
            do_read(a, len, 2);
        end

        check("b_queue_drained", exp_b_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
